// File: rtl/bcd_store_seq.sv
// bcd_store_seq: converts an 8-bit value to three decimal digits and writes them to memory at I, I+1 and I+2
//   clk_i        system clock
//   reset_i      synchronous active-high reset
//   start_i      request pulse, accepted only while idle
//   value_i      value to convert, captured with start_i
//   base_addr_i  base address I, captured with start_i
//   busy_o       high from the cycle after acceptance through the done cycle
//   done_o       one-cycle pulse after the third write completes
//   mem_addr_o   write address
//   mem_wdata_o  zero-extended digit
//   mem_we_o     write request, held until mem_ack_i
//   mem_ack_i    write grant
module bcd_store_seq #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [7:0]        value_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic              mem_ack_i
);
    typedef enum logic [2:0] {IDLE, WR_H, WR_T, WR_O, FIN} state_t;
    state_t            state_q;
    logic              busy_q, done_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        tens_q, ones_q;
    logic [3:0]        hund_d, tens_d, ones_d;
    assign hund_d = 4'(value_i / 8'd100);
    assign tens_d = 4'((value_i / 8'd10) % 8'd10);
    assign ones_d = 4'(value_i % 8'd10);
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= WR_H;
                        busy_q  <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= base_addr_i;
                        wdata_q <= {{(DATA_W-4){1'b0}}, hund_d};
                        tens_q  <= tens_d;
                        ones_q  <= ones_d;
                    end
                end
                // The address register steps by one per accepted write, wrapping at ADDR_W bits.
                WR_H: if (mem_ack_i) begin
                    state_q <= WR_T;
                    addr_q  <= addr_q + ADDR_W'(1);
                    wdata_q <= {{(DATA_W-4){1'b0}}, tens_q};
                end
                WR_T: if (mem_ack_i) begin
                    state_q <= WR_O;
                    addr_q  <= addr_q + ADDR_W'(1);
                    wdata_q <= {{(DATA_W-4){1'b0}}, ones_q};
                end
                WR_O: if (mem_ack_i) begin
                    state_q <= FIN;
                    we_q    <= 1'b0;
                    done_q  <= 1'b1;
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_bcd_store_seq.sv
// tb_bcd_store_seq: randomized self-checking bench for bcd_store_seq against a digit/address model
module tb_bcd_store_seq;
    logic        clk = 1'b0;
    logic        reset_i, start_i, mem_ack_i;
    logic [7:0]  value_i;
    logic [11:0] base_addr_i;
    logic        busy_o, done_o, mem_we_o;
    logic [11:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    int          vecs = 0, errs = 0;
    bcd_store_seq dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .value_i(value_i),
        .base_addr_i(base_addr_i), .busy_o(busy_o), .done_o(done_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
        .mem_ack_i(mem_ack_i)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        vecs++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // One FX33 operation: pct = percent chance of ack low per cycle, t_stalls = forced ack-low
    // cycles while the tens digit is pending, chg = scramble inputs and re-pulse start while busy.
    task automatic run_op(input int v, input int b, input int pct, input int t_stalls, input bit chg);
        int dig[3];
        int k, c, stalls, ts;
        bit dn, ack, forced;
        dig = '{v / 100, (v / 10) % 10, v % 10};
        start_i = 1'b1;
        value_i = v[7:0];
        base_addr_i = b[11:0];
        mem_ack_i = 1'($urandom % 2);
        tick;
        start_i = 1'b0;
        k = 0; c = 1; stalls = 0; ts = t_stalls; dn = 1'b0;
        while (!dn && c < 200) begin
            check("busy", busy_o, 1);
            if (done_o) begin
                check("writes_at_done", k, 3);
                check("we_at_done", mem_we_o, 0);
                check("latency", c, 4 + stalls);
                dn = 1'b1;
            end else begin
                forced = mem_we_o && k == 1 && ts > 0;
                ack = forced ? 1'b0 : ($urandom_range(99) >= pct);
                if (forced) ts--;
                mem_ack_i = ack;
                check("we", mem_we_o, 1);
                if (k < 3) begin
                    check("addr", mem_addr_o, (b + k) % 4096);
                    check("data", mem_wdata_o, dig[k]);
                end else check("extra_write", k, 2);
                if (ack) k++; else stalls++;
            end
            if (chg) begin
                value_i = 8'($urandom);
                base_addr_i = 12'($urandom);
                start_i = 1'($urandom % 2);
            end
            tick;
            c++;
        end
        if (!dn) check("timeout", 0, 1);
        start_i = 1'b0;
        mem_ack_i = 1'($urandom % 2);
        check("busy_after", busy_o, 0);
        check("done_after", done_o, 0);
        check("we_after", mem_we_o, 0);
    endtask
    initial begin
        reset_i = 1'b1; start_i = 1'b0; mem_ack_i = 1'b0; value_i = '0; base_addr_i = '0;
        tick;
        tick;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_data", mem_wdata_o, 0);
        mem_ack_i = 1'b1;
        tick;
        check("rst_ack_ignored", mem_we_o, 0);
        reset_i = 1'b0;
        tick;
        run_op(156, 'h300, 0, 0, 1'b0);
        run_op(255, 'hFFF, 0, 0, 1'b0);
        run_op(7, 'h200, 0, 3, 1'b0);
        run_op(42, 'h123, 0, 0, 1'b1);
        start_i = 1'b1; value_i = 8'd200; base_addr_i = 12'h400; mem_ack_i = 1'b1;
        tick;
        start_i = 1'b0;
        tick;
        check("mid_we", mem_we_o, 1);
        check("mid_addr", mem_addr_o, 'h401);
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        check("abort_we", mem_we_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        for (int i = 0; i < 6; i++) begin
            tick;
            check("abort_no_done", done_o, 0);
            check("abort_idle_we", mem_we_o, 0);
        end
        reset_i = 1'b1; start_i = 1'b1;
        tick;
        reset_i = 1'b0; start_i = 1'b0;
        check("rst_start_busy", busy_o, 0);
        tick;
        check("rst_start_dropped", busy_o, 0);
        check("rst_start_we", mem_we_o, 0);
        run_op(100, 'h010, 0, 0, 1'b0);
        for (int v = 0; v < 256; v++)
            run_op(v, int'($urandom_range(4095)), 30, 0, v % 2 == 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
